// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-master round-robin arbiter onto one shared bus; optional BUS_ARB_TIMEOUT_EN bus timeout.
// Latency: bus_en the cycle after a request is sampled, ack pulse the cycle after i_ack; one transaction in flight, others wait.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_MASTERS-1:0]        i_m_req,
  input  logic [NUM_MASTERS-1:0]        i_m_wr_rd,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_m_wr_data,
  input  logic [NUM_MASTERS*3-1:0]      i_m_size,
  output logic [NUM_MASTERS-1:0]        o_m_ack,
  output logic [NUM_MASTERS-1:0]        o_m_err,
  output logic [DATA_W-1:0]             o_m_rd_data,
  input  logic                          i_ack,
  input  logic [DATA_W-1:0]             i_rd_data,
  output logic                          o_bus_en,
  output logic                          o_wr_rd,
  output logic [ADDR_W-1:0]             o_addr,
  output logic [DATA_W-1:0]             o_wr_data,
  output logic [2:0]                    o_size
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0]   grant_oh;

  logic                     win_found;
  logic [PTR_W-1:0]         win_idx;
  logic                     sel_wr_rd;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;
  logic [2:0]               sel_size;

  logic                     bus_en_d, wr_rd_d;
  logic [ADDR_W-1:0]        addr_d;
  logic [DATA_W-1:0]        wdata_d, rd_data_d;
  logic [2:0]               size_d;
  logic [NUM_MASTERS-1:0]   m_ack_d;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0]   m_err_q, m_err_d;
  logic                     timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_m_err = m_err_q;
`else
  assign o_m_err = '0;
`endif

  // ptr always holds the current/last grant, so it doubles as the grant index.
  assign grant_oh = NUM_MASTERS'(1) << ptr_q;

  // Round-robin search starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!win_found && i_m_req[k] && (k == (int'(ptr_q) + i) % NUM_MASTERS)) begin
          win_found = 1'b1;
          win_idx   = PTR_W'(k);
        end
      end
    end
  end

  always_comb begin
    sel_wr_rd = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (win_idx == PTR_W'(k)) begin
        sel_wr_rd = i_m_wr_rd[k];
        sel_addr  = i_m_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_m_wr_data[k*DATA_W +: DATA_W];
        sel_size  = i_m_size[k*3 +: 3];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    bus_en_d  = o_bus_en;
    wr_rd_d   = o_wr_rd;
    addr_d    = o_addr;
    wdata_d   = o_wr_data;
    size_d    = o_size;
    m_ack_d   = '0;
    rd_data_d = o_m_rd_data;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    m_err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = BUSY;
          ptr_d    = win_idx;
          bus_en_d = 1'b1;
          wr_rd_d  = sel_wr_rd;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          size_d   = sel_size;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        // A simultaneous ack beats the timeout.
        if (i_ack) begin
          state_d   = RESP;
          bus_en_d  = 1'b0;
          m_ack_d   = grant_oh;
          rd_data_d = i_rd_data;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (timeout) begin
          state_d   = RESP;
          bus_en_d  = 1'b0;
          m_ack_d   = grant_oh;
          m_err_d   = grant_oh;
          rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= PTR_W'(NUM_MASTERS - 1);
      o_bus_en    <= 1'b0;
      o_wr_rd     <= 1'b0;
      o_addr      <= '0;
      o_wr_data   <= '0;
      o_size      <= '0;
      o_m_ack     <= '0;
      o_m_rd_data <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      m_err_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      o_bus_en    <= bus_en_d;
      o_wr_rd     <= wr_rd_d;
      o_addr      <= addr_d;
      o_wr_data   <= wdata_d;
      o_size      <= size_d;
      o_m_ack     <= m_ack_d;
      o_m_rd_data <= rd_data_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      m_err_q     <= m_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr (4 masters): directed steps plus random traffic against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, m_wr;
  logic [AW-1:0]  m_addr  [N];
  logic [DW-1:0]  m_wdata [N];
  logic [2:0]     m_size  [N];
  logic [N*AW-1:0] addr_f;
  logic [N*DW-1:0] wdata_f;
  logic [N*3-1:0]  size_f;
  logic [N-1:0]   m_ack, m_err;
  logic [DW-1:0]  m_rd_data;
  logic           ack;
  logic [DW-1:0]  rd_data;
  logic           bus_en, bus_wr_rd;
  logic [AW-1:0]  bus_addr;
  logic [DW-1:0]  bus_wdata;
  logic [2:0]     bus_size;

  int checks = 0;
  int errors = 0;
  int last_grant = N - 1;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_flat
    assign addr_f[k*AW +: AW]  = m_addr[k];
    assign wdata_f[k*DW +: DW] = m_wdata[k];
    assign size_f[k*3 +: 3]    = m_size[k];
  end

  bus_arbiter_rr #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_req(req), .i_m_wr_rd(m_wr), .i_m_addr(addr_f), .i_m_wr_data(wdata_f), .i_m_size(size_f),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_rd_data(m_rd_data),
    .i_ack(ack), .i_rd_data(rd_data),
    .o_bus_en(bus_en), .o_wr_rd(bus_wr_rd), .o_addr(bus_addr), .o_wr_data(bus_wdata), .o_size(bus_size)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner = first requester scanning last+1, last+2, ... last (mod N).
  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    int k;
    for (int i = 1; i <= N; i++) begin
      k = (last + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_master(input int k);
    m_addr[k]  = $urandom;
    m_wdata[k] = $urandom;
    m_size[k]  = 3'($urandom_range(0, 7));
    m_wr[k]    = 1'($urandom_range(0, 1));
    req[k]     = 1'b1;
  endtask

  // Runs one contest from an IDLE cycle. d = BUSY cycles before i_ack, rk = master raised mid-transfer (-1 random, -2 none).
  task automatic txn(input int d, input logic [DW-1:0] rdv, input int rk, output int w);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    logic [2:0]    es;
    bit            tmo;
    int            nb, k;
    w = rr_pick(last_grant, req);
    if (w < 0) begin
      step();
      chk("idle_bus_en", bus_en, 0);
      chk("idle_ack", m_ack, 0);
      return;
    end
    ea = m_addr[w]; ed = m_wdata[w]; ew = m_wr[w]; es = m_size[w];
    step();
    chk("grant_bus_en", bus_en, 1);
    chk("grant_addr", bus_addr, ea);
    chk("grant_wdata", bus_wdata, ed);
    chk("grant_wr_rd", bus_wr_rd, ew);
    chk("grant_size", bus_size, es);
    chk("grant_ack", m_ack, 0);
    last_grant = w;
    tmo = TO_EN && (d >= TO);
    nb  = tmo ? TO - 1 : d;
    for (int c = 0; c < nb; c++) begin
      ack = 1'b0;
      rd_data = $urandom;
      k = $urandom_range(0, N - 1);
      if (rk >= 0 && c == 0 && !req[rk]) set_master(rk);
      else if (rk == -1 && !req[k] && $urandom_range(0, 2) == 0) set_master(k);
      step();
      chk("busy_bus_en", bus_en, 1);
      chk("busy_addr", bus_addr, ea);
      chk("busy_wdata", bus_wdata, ed);
      chk("busy_wr_rd", bus_wr_rd, ew);
      chk("busy_size", bus_size, es);
      chk("busy_ack", m_ack, 0);
    end
    ack = !tmo;
    rd_data = rdv;
    step();
    chk("resp_bus_en", bus_en, 0);
    chk("resp_ack", m_ack, 64'(1) << w);
    chk("resp_err", m_err, tmo ? (64'(1) << w) : 64'(0));
    chk("resp_data", m_rd_data, tmo ? 64'(0) : 64'(rdv));
    req[w]  = 1'b0;
    ack     = 1'($urandom_range(0, 1));
    rd_data = $urandom;
    step();
    chk("done_ack", m_ack, 0);
    chk("done_bus_en", bus_en, 0);
  endtask

  initial begin
    int w, first;
    rst = 1'b1; req = '0; m_wr = '0; ack = 1'b0; rd_data = '0;
    for (int k = 0; k < N; k++) begin m_addr[k] = '0; m_wdata[k] = '0; m_size[k] = '0; end
    #1;
    chk("rst_bus_en", bus_en, 0);
    step(); step();
    chk("rst_wr_rd", bus_wr_rd, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_size", bus_size, 0);
    chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0);
    chk("rst_rd_data", m_rd_data, 0);
    rst = 1'b0;

    // Single read from master 0, zero-wait bus.
    m_addr[0] = 32'h0000_1000; m_wr[0] = 1'b0; m_size[0] = 3'b010; req[0] = 1'b1;
    txn(0, 32'hDEAD_BEEF, -2, w);
    chk("t1_grant", w, 0);
    chk("t1_rd_data_hold", m_rd_data, 32'hDEAD_BEEF);

    // Master 1 write with a delayed ack; master 0 raises mid-transfer and must wait.
    m_addr[1] = 32'h0000_2000; m_wdata[1] = 32'h1234_5678; m_size[1] = 3'b010; m_wr[1] = 1'b1; req[1] = 1'b1;
    txn(5, 32'h0, 0, w);
    chk("t2_grant", w, 1);
    txn(0, $urandom, -2, w);
    chk("t2_next_grant", w, 0);

    // Async reset mid-BUSY on a master-1 transfer; pointer must restart so master 1 beats master 2.
    set_master(1);
    step();
    chk("t3_bus_en", bus_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("t3_async_bus_en", bus_en, 0);
    chk("t3_async_addr", bus_addr, 0);
    req = '0; ack = 1'b0;
    step();
    rst = 1'b0;
    last_grant = N - 1;
    set_master(1); set_master(2);
    txn(0, $urandom, -2, w);
    chk("t3_post_rst_grant", w, 1);

    // All masters request continuously, re-requesting after each ack.
    for (int k = 0; k < N; k++) if (!req[k]) set_master(k);
    first = (last_grant + 1) % N;
    for (int i = 0; i < 2 * N; i++) begin
      txn(0, $urandom, -2, w);
      chk("t4_rr_order", w, (first + i) % N);
      set_master(w);
    end
    req = '0;
    step(); step();

`ifdef BUS_ARB_TIMEOUT_EN
    // Timeout with no ack, then a late ack in IDLE is ignored.
    set_master(3);
    txn(10, $urandom, -2, w);
    chk("t5_grant", w, 3);
    ack = 1'b1;
    step();
    chk("t5_late_ack_bus_en", bus_en, 0);
    chk("t5_late_ack", m_ack, 0);
    ack = 1'b0;
    // Ack lands in the same cycle as the limit: ack wins.
    set_master(2);
    txn(TO - 1, 32'hCAFE_F00D, -2, w);
    chk("t6_data", m_rd_data, 32'hCAFE_F00D);
    chk("t6_err", m_err, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < N; k++) if (!req[k] && $urandom_range(0, 2) == 0) set_master(k);
      txn($urandom_range(0, 6), $urandom, -1, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
